// File: rtl/win_tile_gen.sv
// Raster-to-tile front end: buffers four image rows and emits overlapping 4x4 tiles at stride 2.
// Optional tile coordinate outputs are enabled by defining WIN_TILE_COORD_EN.
module win_tile_gen #(
   parameter int IMG_W     = 16,
   parameter int IMG_H     = 16,
   parameter int PIX_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PIX_WIDTH-1:0]      pix_in,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   output logic [16*PIX_WIDTH-1:0]   tile_out,
   output logic                      tile_valid,
   input  logic                      tile_ready,
   output logic                      tile_last
`ifdef WIN_TILE_COORD_EN
   ,
   output logic [$clog2(IMG_H/2)-1:0] tile_y,
   output logic [$clog2(IMG_W/2)-1:0] tile_x
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]           r_col;
   logic [RW-1:0]           r_row;
   logic [PIX_WIDTH-1:0]    r_lbuf [4][IMG_W];
   logic [16*PIX_WIDTH-1:0] r_tileOut;
   logic                    r_tileValid;
   logic                    r_tileLast;

   logic                    w_accept;
   logic                    w_trigger;
   logic                    w_colEnd;
   logic                    w_rowEnd;
   logic [16*PIX_WIDTH-1:0] w_tile;

   assign pix_ready = !r_tileValid || tile_ready;
   assign w_accept  = pix_valid && pix_ready;
   assign w_colEnd  = (r_col == CW'(IMG_W - 1));
   assign w_rowEnd  = (r_row == RW'(IMG_H - 1));
   assign w_trigger = w_accept && r_row[0] && (r_row >= RW'(3))
                               && r_col[0] && (r_col >= CW'(3));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_colEnd) begin
            r_col <= '0;
            r_row <= w_rowEnd ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Row slots rotate as r mod 4, so no clearing is needed between frames.
   always_ff @(posedge clk) begin
      if (w_accept && !rst) begin
         r_lbuf[r_row[1:0]][r_col] <= pix_in;
      end
   end

   // Tile row i lives in slot (r-3+i) mod 4; the bottom-right pixel bypasses the buffer.
   always_comb begin
      w_tile = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (i == 3 && j == 3) begin
               w_tile[(15 - (4*i + j))*PIX_WIDTH +: PIX_WIDTH] = pix_in;
            end else begin
               w_tile[(15 - (4*i + j))*PIX_WIDTH +: PIX_WIDTH] =
                  r_lbuf[r_row[1:0] + 2'(i + 1)][r_col - CW'(3 - j)];
            end
         end
      end
   end

`ifdef WIN_TILE_COORD_EN
   localparam int XW = $clog2(IMG_W/2);
   localparam int YW = $clog2(IMG_H/2);

   logic [CW-1:0] w_colM3;
   logic [RW-1:0] w_rowM3;
   logic [XW-1:0] r_tileX;
   logic [YW-1:0] r_tileY;

   assign w_colM3 = r_col - CW'(3);
   assign w_rowM3 = r_row - RW'(3);
   assign tile_x  = r_tileX;
   assign tile_y  = r_tileY;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tileX <= '0;
         r_tileY <= '0;
      end else if (w_trigger) begin
         r_tileX <= XW'(w_colM3 >> 1);
         r_tileY <= YW'(w_rowM3 >> 1);
      end
   end
`endif

   // Triggers only occur on a handshake, which implies the previous tile is gone or leaving.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tileOut   <= '0;
         r_tileValid <= 1'b0;
         r_tileLast  <= 1'b0;
      end else if (w_trigger) begin
         r_tileOut   <= w_tile;
         r_tileValid <= 1'b1;
         r_tileLast  <= w_colEnd && w_rowEnd;
      end else if (tile_ready) begin
         r_tileValid <= 1'b0;
      end
   end

   assign tile_out   = r_tileOut;
   assign tile_valid = r_tileValid;
   assign tile_last  = r_tileLast;

endmodule

// File: tb/tb_win_tile_gen.sv
// Scoreboard bench for win_tile_gen on an 8x8 image with pixel value 8r+c.
// Coordinate checks are compiled in only when WIN_TILE_COORD_EN is defined.
module tb_win_tile_gen;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int PW = 8;
   localparam logic [127:0] FIRST_TILE = 128'h00010203_08090A0B_10111213_18191A1B;
   localparam logic [127:0] LAST_TILE  = 128'h24252627_2C2D2E2F_34353637_3C3D3E3F;

   logic           clk = 1'b0;
   logic           rst;
   logic [PW-1:0]  pix_in;
   logic           pix_valid;
   logic           tile_ready;
   logic           pix_ready;
   logic [127:0]   tile_out;
   logic           tile_valid;
   logic           tile_last;
`ifdef WIN_TILE_COORD_EN
   logic [1:0]     tile_y;
   logic [1:0]     tile_x;
`endif

   win_tile_gen #(.IMG_W(W), .IMG_H(H), .PIX_WIDTH(PW)) dut (
      .clk(clk),
      .rst(rst),
      .pix_in(pix_in),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .tile_out(tile_out),
      .tile_valid(tile_valid),
      .tile_ready(tile_ready),
      .tile_last(tile_last)
`ifdef WIN_TILE_COORD_EN
      ,
      .tile_y(tile_y),
      .tile_x(tile_x)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] data;
      logic         last;
      logic [1:0]   x;
      logic [1:0]   y;
   } exp_t;

   exp_t         expQ[$];
   int           errors = 0;
   int           checks = 0;
   int           tilesSeen = 0;
   int           mr = 0;
   int           mc = 0;
   int           firstTrigIdx = -1;
   logic [127:0] firstTile = '0;
   logic [127:0] lastTileSeen = '0;

   function automatic exp_t modelTile(int r, int c);
      exp_t e;
      e.data = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            e.data[(15 - (4*i + j))*8 +: 8] = 8'(8*(r - 3 + i) + (c - 3 + j));
      e.last = (r == H - 1) && (c == W - 1);
      e.x    = 2'((c - 3) / 2);
      e.y    = 2'((r - 3) / 2);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: a tile is consumed whenever valid and ready are both high at the coming edge.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (tile_valid === 1'b1 && tile_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedTile: got %h expected none", tile_out);
         end else begin
            e = expQ.pop_front();
            checkOutput("tileData", tile_out, e.data);
            checkOutput("tileLast", {127'b0, tile_last}, {127'b0, e.last});
`ifdef WIN_TILE_COORD_EN
            checkOutput("tileX", {126'b0, tile_x}, {126'b0, e.x});
            checkOutput("tileY", {126'b0, tile_y}, {126'b0, e.y});
`endif
            if (tilesSeen == 0) firstTile = tile_out;
            lastTileSeen = tile_out;
            tilesSeen++;
         end
      end
   end

   // mode 0: steady stream, mode 1: random valid/ready; holdFirst stalls the first tile 5 cycles.
   task automatic applyStimulus(input int nPix, input int mode, input bit holdFirst, input bit readyAfter);
      int           sent = 0;
      int           budget = 0;
      int           holdCnt = 0;
      bit           trigPend = 0;
      logic [127:0] held = '0;
      while (sent < nPix && budget < 5000) begin
         @(negedge clk);
         if (trigPend) begin
            checkOutput("latency", {127'b0, tile_valid}, 128'd1);
            trigPend = 0;
         end
         tile_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (holdFirst && tile_valid && holdCnt < 5) begin
            tile_ready = 1'b0;
            if (holdCnt == 0) held = tile_out;
            else checkOutput("stallData", tile_out, held);
            holdCnt++;
         end
         pix_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         pix_in    = 8'(8*mr + mc);
         #1;
         if (holdFirst && !tile_ready)
            checkOutput("stallReady", {127'b0, pix_ready}, 128'd0);
         if (pix_valid && pix_ready) begin
            if ((mr % 2 == 1) && mr >= 3 && (mc % 2 == 1) && mc >= 3) begin
               expQ.push_back(modelTile(mr, mc));
               trigPend = 1;
               if (firstTrigIdx < 0) firstTrigIdx = mr*W + mc;
            end
            if (mc == W - 1) begin
               mc = 0;
               mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
               mc++;
            end
            sent++;
         end
         budget++;
      end
      if (budget >= 5000) begin
         checks++;
         errors++;
         $display("[TB] FAIL stimulusTimeout: got %0d pixels expected %0d", sent, nPix);
      end
      @(negedge clk);
      if (trigPend) checkOutput("latency", {127'b0, tile_valid}, 128'd1);
      pix_valid  = 1'b0;
      tile_ready = readyAfter;
   endtask

   task automatic drain(input int expTiles, input string name);
      tile_ready = 1'b1;
      pix_valid  = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput({name, "QueueEmpty"}, 128'(expQ.size()), 128'd0);
      checkOutput({name, "TileCount"}, 128'(tilesSeen), 128'(expTiles));
   endtask

   task automatic startFrame();
      tilesSeen    = 0;
      firstTrigIdx = -1;
      firstTile    = '0;
      lastTileSeen = '0;
   endtask

   initial begin
      rst        = 1'b1;
      pix_valid  = 1'b0;
      tile_ready = 1'b1;
      pix_in     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("resetValid", {127'b0, tile_valid}, 128'd0);
      checkOutput("resetLast", {127'b0, tile_last}, 128'd0);
      checkOutput("resetData", tile_out, 128'd0);
      checkOutput("resetReady", {127'b0, pix_ready}, 128'd1);
`ifdef WIN_TILE_COORD_EN
      checkOutput("resetCoord", {124'b0, tile_x, tile_y}, 128'd0);
`endif

      $display("[TB] full frame, steady stream");
      startFrame();
      applyStimulus(64, 0, 0, 1'b1);
      drain(9, "fullFrame");
      checkOutput("firstTrigIdx", 128'(firstTrigIdx), 128'd27);
      checkOutput("firstTile", firstTile, FIRST_TILE);
      checkOutput("lastTile", lastTileSeen, LAST_TILE);

      $display("[TB] back-pressure on first tile");
      startFrame();
      applyStimulus(64, 0, 1, 1'b1);
      drain(9, "backPressure");
      checkOutput("bpFirstTile", firstTile, FIRST_TILE);
      checkOutput("bpLastTile", lastTileSeen, LAST_TILE);

      $display("[TB] random stalls over two frames");
      startFrame();
      applyStimulus(128, 1, 0, 1'b1);
      drain(18, "randomStall");
      checkOutput("rsLastTile", lastTileSeen, LAST_TILE);

      $display("[TB] reset mid-frame");
      startFrame();
      applyStimulus(30, 0, 0, 1'b0);
      rst       = 1'b1;
      pix_valid = 1'b1;
      pix_in    = 8'hEE;
      expQ.delete();
      @(negedge clk);
      rst       = 1'b0;
      pix_valid = 1'b0;
      checkOutput("midResetValid", {127'b0, tile_valid}, 128'd0);
      checkOutput("midResetReady", {127'b0, pix_ready}, 128'd1);
      tile_ready = 1'b1;
      mr = 0;
      mc = 0;
      startFrame();
      applyStimulus(64, 0, 0, 1'b1);
      drain(9, "afterReset");
      checkOutput("arFirstTrigIdx", 128'(firstTrigIdx), 128'd27);
      checkOutput("arFirstTile", firstTile, FIRST_TILE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      checks++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
